// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - packet-atomic round-robin arbiter for the PCIe core transmit stream
module pcie_tx_arbiter #(
    parameter int          C_DATA_WIDTH = 64,
    parameter int          KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter logic [5:0]  BUF_AV_MIN   = 6'd1
) (
    input  logic                    user_clk,
    input  logic                    user_reset,
    input  logic                    user_lnk_up,
    input  logic [5:0]              tx_buf_av,
    input  logic                    tx_cfg_req,
    output logic                    tx_cfg_gnt,

    input  logic                    src0_tvalid,
    input  logic [C_DATA_WIDTH-1:0] src0_tdata,
    input  logic [KEEP_WIDTH-1:0]   src0_tkeep,
    input  logic [3:0]              src0_tuser,
    input  logic                    src0_tlast,
    output logic                    src0_tready,

    input  logic                    src1_tvalid,
    input  logic [C_DATA_WIDTH-1:0] src1_tdata,
    input  logic [KEEP_WIDTH-1:0]   src1_tkeep,
    input  logic [3:0]              src1_tuser,
    input  logic                    src1_tlast,
    output logic                    src1_tready,

    output logic                    s_axis_tx_tvalid,
    output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
    output logic [3:0]              s_axis_tx_tuser,
    output logic                    s_axis_tx_tlast,
    input  logic                    s_axis_tx_tready,

    output logic [1:0]              grant,
    output logic [15:0]             drop_count
);

    typedef enum logic [2:0] {IDLE, SRC0, SRC1, CFG, DRAIN} state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   last_grant_nxt;
    logic   pick;
    logic   drop_inc;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            drop_count <= 16'd0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (drop_inc && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        drop_inc       = 1'b0;
        pick           = 1'b0;
        case (state)
            IDLE: begin
                if (user_lnk_up) begin
                    if (tx_cfg_req) begin
                        state_nxt = CFG;
                    end else if (tx_buf_av >= BUF_AV_MIN && (src0_tvalid || src1_tvalid)) begin
                        // On a tie the source that did not go last wins
                        pick           = (src0_tvalid && src1_tvalid) ? ~last_grant : src1_tvalid;
                        state_nxt      = pick ? SRC1 : SRC0;
                        last_grant_nxt = pick;
                    end
                end
            end
            SRC0: begin
                if (src0_tvalid && s_axis_tx_tready && src0_tlast) begin
                    state_nxt = IDLE;
                end else if (!user_lnk_up) begin
                    state_nxt = DRAIN;
                end
            end
            SRC1: begin
                if (src1_tvalid && s_axis_tx_tready && src1_tlast) begin
                    state_nxt = IDLE;
                end else if (!user_lnk_up) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // last_grant still names the source whose packet is being discarded
                if (last_grant ? (src1_tvalid && src1_tlast) : (src0_tvalid && src0_tlast)) begin
                    state_nxt = IDLE;
                    drop_inc  = 1'b1;
                end
            end
            CFG: begin
                if (!tx_cfg_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tx_tvalid = 1'b0;
        s_axis_tx_tdata  = '0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tuser  = 4'd0;
        s_axis_tx_tlast  = 1'b0;
        src0_tready      = 1'b0;
        src1_tready      = 1'b0;
        tx_cfg_gnt       = 1'b0;
        grant            = 2'b00;
        case (state)
            SRC0: begin
                s_axis_tx_tvalid = src0_tvalid;
                s_axis_tx_tdata  = src0_tdata;
                s_axis_tx_tkeep  = src0_tkeep;
                s_axis_tx_tuser  = src0_tuser;
                s_axis_tx_tlast  = src0_tlast;
                src0_tready      = s_axis_tx_tready;
                grant            = 2'b01;
            end
            SRC1: begin
                s_axis_tx_tvalid = src1_tvalid;
                s_axis_tx_tdata  = src1_tdata;
                s_axis_tx_tkeep  = src1_tkeep;
                s_axis_tx_tuser  = src1_tuser;
                s_axis_tx_tlast  = src1_tlast;
                src1_tready      = s_axis_tx_tready;
                grant            = 2'b10;
            end
            DRAIN: begin
                src0_tready = ~last_grant;
                src1_tready = last_grant;
            end
            CFG:     tx_cfg_gnt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb/tb_pcie_tx_arbiter.sv - self-checking bench for pcie_tx_arbiter
module tb_pcie_tx_arbiter;
    localparam int DW = 64;
    localparam int KW = 8;

    logic          user_clk = 1'b0;
    logic          user_reset, user_lnk_up, tx_cfg_req, tx_cfg_gnt;
    logic [5:0]    tx_buf_av;
    logic          src0_tvalid, src0_tlast, src0_tready;
    logic [DW-1:0] src0_tdata;
    logic [KW-1:0] src0_tkeep;
    logic [3:0]    src0_tuser;
    logic          src1_tvalid, src1_tlast, src1_tready;
    logic [DW-1:0] src1_tdata;
    logic [KW-1:0] src1_tkeep;
    logic [3:0]    src1_tuser;
    logic          s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tready;
    logic [DW-1:0] s_axis_tx_tdata;
    logic [KW-1:0] s_axis_tx_tkeep;
    logic [3:0]    s_axis_tx_tuser;
    logic [1:0]    grant;
    logic [15:0]   drop_count;

    always #5 user_clk = ~user_clk;

    pcie_tx_arbiter #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .BUF_AV_MIN(6'd1)) dut (
        .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
        .tx_buf_av(tx_buf_av), .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
        .src0_tvalid(src0_tvalid), .src0_tdata(src0_tdata), .src0_tkeep(src0_tkeep),
        .src0_tuser(src0_tuser), .src0_tlast(src0_tlast), .src0_tready(src0_tready),
        .src1_tvalid(src1_tvalid), .src1_tdata(src1_tdata), .src1_tkeep(src1_tkeep),
        .src1_tuser(src1_tuser), .src1_tlast(src1_tlast), .src1_tready(src1_tready),
        .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tdata(s_axis_tx_tdata),
        .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tuser(s_axis_tx_tuser),
        .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tready(s_axis_tx_tready),
        .grant(grant), .drop_count(drop_count)
    );

    int total = 0;
    int bad   = 0;

    // Per-source packet queues; word = {src, packet id, beat, random}
    logic [63:0] qd [2][$];
    logic        ql [2][$];
    logic [1:0]  v;
    int          vprob, rdy_mode, pid, pushed, core_pkts, core_beats, cur_owner;
    logic        tog, in_pkt;
    int          pkt_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int s, input int len);
        for (int b = 0; b < len; b++) begin
            qd[s].push_back({4'(s), 12'(pid), 16'(b), 32'($urandom())});
            ql[s].push_back(b == len - 1);
        end
        pid++;
        pushed++;
    endtask

    task automatic adv();
        @(posedge user_clk);
        #1;
    endtask

    // Drive one cycle of source/core stimulus, then score the handshakes it produces
    task automatic drive_sample();
        for (int s = 0; s < 2; s++) begin
            if (!v[s] && qd[s].size() > 0 && $urandom_range(99) < vprob) v[s] = 1'b1;
        end
        src0_tvalid = v[0];
        src0_tdata  = v[0] ? qd[0][0] : '0;
        src0_tlast  = v[0] ? ql[0][0] : 1'b0;
        src0_tkeep  = v[0] ? '1 : '0;
        src0_tuser  = v[0] ? qd[0][0][3:0] : 4'd0;
        src1_tvalid = v[1];
        src1_tdata  = v[1] ? qd[1][0] : '0;
        src1_tlast  = v[1] ? ql[1][0] : 1'b0;
        src1_tkeep  = v[1] ? '1 : '0;
        src1_tuser  = v[1] ? qd[1][0][3:0] : 4'd0;
        tog = ~tog;
        case (rdy_mode)
            0:       s_axis_tx_tready = 1'b1;
            1:       s_axis_tx_tready = tog;
            default: s_axis_tx_tready = 1'($urandom_range(1));
        endcase
        #1;
        if (s_axis_tx_tvalid) check("cfg_excl", tx_cfg_gnt, 1'b0);
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
            int o;
            o = int'(s_axis_tx_tdata[63:60]);
            check("owner_range", o < 2, 1'b1);
            if (o < 2 && qd[o].size() > 0) begin
                check("beat_data", s_axis_tx_tdata, qd[o][0]);
                check("beat_last", s_axis_tx_tlast, ql[o][0]);
                check("beat_user", s_axis_tx_tuser, qd[o][0][3:0]);
                check("src_ready", (o == 1) ? src1_tready : src0_tready, 1'b1);
                if (in_pkt) check("no_interleave", o, cur_owner);
                core_beats++;
                if (s_axis_tx_tlast) begin
                    in_pkt = 1'b0;
                    core_pkts++;
                    pkt_log.push_back(o);
                end else begin
                    in_pkt    = 1'b1;
                    cur_owner = o;
                end
            end
        end
        if (src0_tvalid && src0_tready) begin void'(qd[0].pop_front()); void'(ql[0].pop_front()); v[0] = 1'b0; end
        if (src1_tvalid && src1_tready) begin void'(qd[1].pop_front()); void'(ql[1].pop_front()); v[1] = 1'b0; end
    endtask

    task automatic do_reset();
        for (int s = 0; s < 2; s++) begin qd[s].delete(); ql[s].delete(); end
        pkt_log.delete();
        v = 2'b00; pid = 0; pushed = 0; core_pkts = 0; core_beats = 0;
        in_pkt = 1'b0; cur_owner = 0; vprob = 100; rdy_mode = 0; tog = 1'b1;
        user_reset = 1'b1; user_lnk_up = 1'b1; tx_buf_av = 6'd8; tx_cfg_req = 1'b0;
        src0_tvalid = 0; src0_tdata = '0; src0_tkeep = '0; src0_tuser = '0; src0_tlast = 0;
        src1_tvalid = 0; src1_tdata = '0; src1_tkeep = '0; src1_tuser = '0; src1_tlast = 0;
        s_axis_tx_tready = 1'b1;
        repeat (2) @(posedge user_clk);
        #1 user_reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_rdy0", src0_tready, 1'b0);
        check("rst_rdy1", src1_tready, 1'b0);
        check("rst_tvalid", s_axis_tx_tvalid, 1'b0);
        check("rst_cfg_gnt", tx_cfg_gnt, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_drop", drop_count, 16'd0);

        // Three-beat src0 TLP, tready held high
        push_pkt(0, 3);
        drive_sample();
        check("t1_c0_grant", grant, 2'b00);
        check("t1_c0_tvalid", s_axis_tx_tvalid, 1'b0);
        adv();
        for (int c = 1; c <= 3; c++) begin
            drive_sample();
            check("t1_tvalid", s_axis_tx_tvalid, 1'b1);
            check("t1_grant", grant, 2'b01);
            check("t1_tlast", s_axis_tx_tlast, c == 3);
            adv();
        end
        drive_sample();
        check("t1_c4_grant", grant, 2'b00);
        check("t1_beats", core_beats, 3);
        adv();

        // Both sources saturated with 2-beat TLPs: strict alternation from src0
        do_reset();
        push_pkt(0, 2); push_pkt(1, 2); push_pkt(0, 2); push_pkt(1, 2);
        repeat (14) begin drive_sample(); adv(); end
        check("t2_pkts", pkt_log.size(), 4);
        for (int i = 0; i < 4 && i < pkt_log.size(); i++) check("t2_order", pkt_log[i], i % 2);

        // Config request arriving during a src1 TLP
        do_reset();
        push_pkt(1, 3);
        drive_sample(); adv();
        tx_cfg_req = 1'b1;
        drive_sample();
        check("t3_c1_grant", grant, 2'b10);
        check("t3_c1_gnt", tx_cfg_gnt, 1'b0);
        adv();
        push_pkt(0, 2);
        drive_sample();
        check("t3_c2_grant", grant, 2'b10);
        check("t3_c2_rdy0", src0_tready, 1'b0);
        adv();
        drive_sample();
        check("t3_c3_tlast", s_axis_tx_tlast, 1'b1);
        adv();
        drive_sample();
        check("t3_c4_grant", grant, 2'b00);
        check("t3_c4_gnt", tx_cfg_gnt, 1'b0);
        adv();
        for (int c = 5; c <= 7; c++) begin
            if (c == 7) tx_cfg_req = 1'b0;
            drive_sample();
            check("t3_cfg_gnt", tx_cfg_gnt, 1'b1);
            check("t3_cfg_rdy0", src0_tready, 1'b0);
            check("t3_cfg_tvalid", s_axis_tx_tvalid, 1'b0);
            adv();
        end
        drive_sample();
        check("t3_c8_gnt", tx_cfg_gnt, 1'b0);
        check("t3_c8_grant", grant, 2'b00);
        adv();
        drive_sample();
        check("t3_c9_grant", grant, 2'b01);
        adv();
        repeat (3) begin drive_sample(); adv(); end
        check("t3_drained", qd[0].size() + qd[1].size(), 0);

        // No buffers: hold off; single-beat TLP once buffers appear
        do_reset();
        tx_buf_av = 6'd0;
        push_pkt(0, 1);
        for (int c = 0; c < 3; c++) begin
            drive_sample();
            check("t4_nogrant", grant, 2'b00);
            check("t4_rdy0", src0_tready, 1'b0);
            adv();
        end
        tx_buf_av = 6'd1;
        drive_sample();
        check("t4_c3_grant", grant, 2'b00);
        adv();
        drive_sample();
        check("t4_c4_grant", grant, 2'b01);
        check("t4_c4_tlast", s_axis_tx_tlast, 1'b1);
        adv();
        drive_sample();
        check("t4_c5_grant", grant, 2'b00);
        adv();

        // Link drop during beat 2 of a 5-beat TLP
        do_reset();
        push_pkt(0, 5);
        drive_sample(); adv();
        drive_sample(); check("t5_c1_grant", grant, 2'b01); adv();
        user_lnk_up = 1'b0;
        drive_sample(); check("t5_c2_tvalid", s_axis_tx_tvalid, 1'b1); adv();
        for (int c = 3; c <= 5; c++) begin
            drive_sample();
            check("t5_drain_tvalid", s_axis_tx_tvalid, 1'b0);
            check("t5_drain_rdy0", src0_tready, 1'b1);
            check("t5_drain_grant", grant, 2'b00);
            check("t5_drain_cnt", drop_count, 16'd0);
            adv();
        end
        check("t5_q_empty", qd[0].size(), 0);
        push_pkt(0, 1);
        drive_sample();
        check("t5_c6_drop", drop_count, 16'd1);
        check("t5_c6_grant", grant, 2'b00);
        check("t5_c6_rdy0", src0_tready, 1'b0);
        adv();
        drive_sample(); check("t5_c7_grant", grant, 2'b00); adv();
        user_lnk_up = 1'b1;
        drive_sample(); check("t5_c8_grant", grant, 2'b00); adv();
        drive_sample(); check("t5_c9_grant", grant, 2'b01); adv();
        drive_sample(); adv();
        check("t5_q_done", qd[0].size(), 0);
        check("t5_beats", core_beats, 3);

        // Reset mid-packet abandons the TLP without counting it
        push_pkt(0, 3);
        drive_sample(); adv();
        drive_sample(); adv();
        user_reset = 1'b1;
        adv();
        check("t5_rst_grant", grant, 2'b00);
        check("t5_rst_drop", drop_count, 16'd0);
        check("t5_rst_rdy0", src0_tready, 1'b0);

        // Core tready toggling 1,0,1,0 during a TLP
        do_reset();
        rdy_mode = 1;
        push_pkt(0, 4);
        drive_sample(); adv();
        drive_sample(); adv();
        drive_sample();
        check("t6_hold_tvalid", s_axis_tx_tvalid, 1'b1);
        adv();
        repeat (9) begin drive_sample(); adv(); end
        check("t6_beats", core_beats, 4);
        check("t6_pkts", core_pkts, 1);
        check("t6_q_empty", qd[0].size(), 0);

        // Randomized traffic with back-pressure, buffer starvation and config requests
        do_reset();
        rdy_mode = 2;
        vprob = 60;
        for (int c = 0; c < 1500; c++) begin
            if (c < 1200) begin
                for (int s = 0; s < 2; s++) if (qd[s].size() < 3) push_pkt(s, $urandom_range(1, 4));
            end
            tx_buf_av = 6'($urandom_range(0, 3));
            if (!tx_cfg_req && $urandom_range(40) == 0) tx_cfg_req = 1'b1;
            else if (tx_cfg_req && tx_cfg_gnt && $urandom_range(3) == 0) tx_cfg_req = 1'b0;
            drive_sample();
            adv();
        end
        tx_cfg_req = 1'b0; tx_buf_av = 6'd8; rdy_mode = 0; vprob = 100;
        repeat (60) begin drive_sample(); adv(); end
        check("rnd_q_empty", qd[0].size() + qd[1].size(), 0);
        check("rnd_pkts", core_pkts, pushed);
        check("rnd_drop", drop_count, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
